// File: rtl/tri_assembler.sv
// tri_assembler: groups a vertex stream into triangle-list primitives.
// Three consecutive vertices become one packed triangle {v2, v1, v0}, with v0
// in the LSBs. A flush drops a partially collected triangle.
// Optional feature macro: TRI_ASSEMBLER_DEGEN_CULL_EN drops degenerate
// triangles (any two vertices bitwise equal) and counts them in cull_count.
// Without it every triangle is emitted and cull_count is tied to 0.
module tri_assembler #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_in,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 rdy_in,
  input  logic                 flush,
  output logic                 vld_out,
  output logic [3*WIDTH-1:0]   data_out,
  input  logic                 rdy_out,
  output logic [CNT_W-1:0]     tri_count,
  output logic [CNT_W-1:0]     cull_count
);

  localparam logic [1:0] S_V0  = 2'd0;
  localparam logic [1:0] S_V1  = 2'd1;
  localparam logic [1:0] S_V2  = 2'd2;
  localparam logic [1:0] S_OUT = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] v0, v1;
  logic             in_xfer, out_xfer, degen;

  // The triangle is presented for exactly as long as the FSM sits in S_OUT.
  assign vld_out  = (state == S_OUT);
  assign in_xfer  = vld_in && rdy_in;
  assign out_xfer = vld_out && rdy_out;

  // Input readiness: flush blocks consumption while vertices are held, and a
  // presented triangle only accepts the next v0 when it is leaving this cycle.
  always_comb begin
    rdy_in = 1'b0;
    case (state)
      S_V0:    rdy_in = 1'b1;
      S_V1:    rdy_in = !flush;
      S_V2:    rdy_in = !flush;
      S_OUT:   rdy_in = rdy_out;
      default: rdy_in = 1'b0;
    endcase
  end

`ifdef TRI_ASSEMBLER_DEGEN_CULL_EN
  // data_in is the incoming v2 when this is consulted.
  assign degen = (v0 == v1) || (v1 == data_in) || (v0 == data_in);

  // Count triangles dropped as degenerate; wraps freely.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cull_count <= '0;
    else if (state == S_V2 && in_xfer && degen)
      cull_count <= cull_count + CNT_W'(1);
  end
`else
  assign degen      = 1'b0;
  assign cull_count = '0;
`endif

  // Collection FSM: latch v0/v1, assemble on v2, hold until downstream takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_V0;
      v0       <= '0;
      v1       <= '0;
      data_out <= '0;
    end else begin
      case (state)
        S_V0: if (in_xfer) begin
          v0    <= data_in;
          state <= S_V1;
        end
        S_V1: if (flush) state <= S_V0;
        else if (in_xfer) begin
          v1    <= data_in;
          state <= S_V2;
        end
        S_V2: if (flush) state <= S_V0;
        else if (in_xfer) begin
          if (degen) state <= S_V0;
          else begin
            data_out <= {data_in, v1, v0};
            state    <= S_OUT;
          end
        end
        S_OUT: if (out_xfer) begin
          if (in_xfer) begin
            v0    <= data_in;
            state <= S_V1;
          end else begin
            state <= S_V0;
          end
        end
        default: state <= S_V0;
      endcase
    end
  end

  // Count emitted triangles; wraps freely.
  always_ff @(posedge clk) begin
    if (!rst_n)
      tri_count <= '0;
    else if (out_xfer)
      tri_count <= tri_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_tri_assembler.sv
// Bench for tri_assembler: directed vectors with literal expectations, plus a
// vertex-list model checked against the DUT on every cycle.
module tb_tri_assembler;

  localparam int W = 64;
  localparam int C = 16;
`ifdef TRI_ASSEMBLER_DEGEN_CULL_EN
  localparam bit CULL = 1'b1;
`else
  localparam bit CULL = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           vld_in = 1'b0;
  logic [W-1:0]   data_in = '0;
  logic           rdy_in;
  logic           flush = 1'b0;
  logic           vld_out;
  logic [3*W-1:0] data_out;
  logic           rdy_out = 1'b1;
  logic [C-1:0]   tri_count, cull_count;

  tri_assembler #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .data_in(data_in),
    .rdy_in(rdy_in), .flush(flush), .vld_out(vld_out), .data_out(data_out),
    .rdy_out(rdy_out), .tri_count(tri_count), .cull_count(cull_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: list of pending vertices, an optional held triangle, two counters.
  bit             m_valid = 1'b0;
  int             m_npend = 0;
  logic [W-1:0]   m_pend [3];
  bit             m_held = 1'b0;
  logic [3*W-1:0] m_tri = '0;
  logic [C-1:0]   m_tris = '0;
  logic [C-1:0]   m_culls = '0;

  task automatic chk(input string name, input logic [3*W-1:0] act, input logic [3*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_rdy();
    if (m_held) return rdy_out;
    if (m_npend > 0) return !flush;
    return 1'b1;
  endfunction

  // One clock: compare at negedge, advance the model with the inputs that the
  // coming posedge will see, then return just after that posedge.
  task automatic tick();
    logic ex_rdy, in_x;
    @(negedge clk);
    if (m_valid) begin
      chk("model rdy_in", rdy_in, exp_rdy());
      chk("model vld_out", vld_out, m_held);
      if (m_held) chk("model data_out", data_out, m_tri);
      chk("model tri_count", tri_count, m_tris);
      chk("model cull_count", cull_count, m_culls);
    end
    if (!rst_n) begin
      m_valid = 1'b1; m_npend = 0; m_held = 1'b0; m_tris = '0; m_culls = '0;
    end else if (m_valid) begin
      ex_rdy = exp_rdy();
      in_x   = vld_in && ex_rdy;
      if (m_held) begin
        if (rdy_out) begin
          m_held = 1'b0;
          m_tris = m_tris + 1'b1;
          if (in_x) begin m_pend[0] = data_in; m_npend = 1; end
        end
      end else if (m_npend > 0 && flush) begin
        m_npend = 0;
      end else if (in_x) begin
        m_pend[m_npend] = data_in;
        m_npend++;
        if (m_npend == 3) begin
          m_npend = 0;
          if (CULL && (m_pend[0] == m_pend[1] || m_pend[1] == m_pend[2] ||
                       m_pend[0] == m_pend[2]))
            m_culls = m_culls + 1'b1;
          else begin
            m_held = 1'b1;
            m_tri  = {m_pend[2], m_pend[1], m_pend[0]};
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vld_in = 1'b0; flush = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [W-1:0] v);
    vld_in = 1'b1; data_in = v;
    tick();
    vld_in = 1'b0;
  endtask

  function automatic logic [3*W-1:0] tri3(input logic [W-1:0] a, b, c);
    return {c, b, a};
  endfunction

  initial begin
    // Reset state
    rst_n = 1'b0; rdy_out = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    chk("reset rdy_in", rdy_in, 1);
    chk("reset vld_out", vld_out, 0);
    chk("reset data_out", data_out, 0);
    chk("reset tri_count", tri_count, 0);
    chk("reset cull_count", cull_count, 0);

    // Basic list
    push(64'h11); push(64'h22); push(64'h33);
    chk("basic vld_out", vld_out, 1);
    chk("basic data_out", data_out, tri3(64'h11, 64'h22, 64'h33));
    tick();
    chk("basic tri_count", tri_count, 1);
    chk("basic vld_out after xfer", vld_out, 0);

    // Streaming 1..9 with no input stalls
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      vld_in = 1'b1; data_in = W'(i);
      chk("stream rdy_in", rdy_in, 1);
      tick();
      if (i % 3 == 0)
        chk("stream data_out", data_out, tri3(W'(i-2), W'(i-1), W'(i)));
    end
    vld_in = 1'b0;
    tick();
    chk("stream tri_count", tri_count, 3);

    // Backpressure: held triangle, 0xA waiting
    do_reset();
    rdy_out = 1'b0;
    push(64'h1); push(64'h2); push(64'h3);
    vld_in = 1'b1; data_in = 64'hA;
    for (int i = 0; i < 5; i++) begin
      chk("bp rdy_in", rdy_in, 0);
      chk("bp data_out", data_out, tri3(64'h1, 64'h2, 64'h3));
      tick();
    end
    rdy_out = 1'b1;
    chk("bp release rdy_in", rdy_in, 1);
    tick();
    chk("bp tri_count", tri_count, 1);
    chk("bp vld_out", vld_out, 0);
    push(64'hB); push(64'hC);
    chk("bp next data_out", data_out, tri3(64'hA, 64'hB, 64'hC));
    tick();

    // Flush drops partial triangle and blocks the concurrent vertex
    do_reset();
    push(64'h1); push(64'h2);
    flush = 1'b1; vld_in = 1'b1; data_in = 64'h3;
    chk("flush rdy_in", rdy_in, 0);
    tick();
    flush = 1'b0; vld_in = 1'b0;
    push(64'h4); push(64'h5); push(64'h6);
    chk("flush data_out", data_out, tri3(64'h4, 64'h5, 64'h6));
    tick();

    // Reset mid-triangle
    push(64'h1); push(64'h2);
    do_reset();
    chk("midrst vld_out", vld_out, 0);
    chk("midrst tri_count", tri_count, 0);
    chk("midrst rdy_in", rdy_in, 1);
    push(64'h7); push(64'h8); push(64'h9);
    chk("midrst data_out", data_out, tri3(64'h7, 64'h8, 64'h9));
    tick();

    // Flush ignored in S_V0 and S_OUT
    do_reset();
    flush = 1'b1;
    chk("flush v0 rdy_in", rdy_in, 1);
    push(64'h21);
    flush = 1'b0;
    push(64'h22); push(64'h23);
    rdy_out = 1'b0; flush = 1'b1;
    tick();
    chk("flush out vld_out", vld_out, 1);
    flush = 1'b0; rdy_out = 1'b1;
    tick();
    chk("flush out tri_count", tri_count, 1);

    // Degenerate triangle
    do_reset();
    push(64'h5); push(64'h5); push(64'h6);
    if (CULL) begin
      chk("cull vld_out", vld_out, 0);
      chk("cull cull_count", cull_count, 1);
      chk("cull tri_count", tri_count, 0);
      chk("cull rdy_in", rdy_in, 1);
    end else begin
      chk("nocull vld_out", vld_out, 1);
      chk("nocull data_out", data_out, tri3(64'h5, 64'h5, 64'h6));
      tick();
      chk("nocull tri_count", tri_count, 1);
      chk("nocull cull_count", cull_count, 0);
    end
    push(64'h40); push(64'h41); push(64'h42);
    chk("post data_out", data_out, tri3(64'h40, 64'h41, 64'h42));
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
